buzz_note_scheduler: RTL and testbench
======================================

BUZZ_NOTE_SCHEDULER -- requirements
Module: buzz_note_scheduler

Interface
REQ-001 Parameter DIV0..DIV6, defaults 95557, 85131, 75843, 71586, 63776, 56818, 50619: half-period in clk cycles for notes C4..B4 (note index 0..6) at a 50 MHz clk.
REQ-002 Parameter GAP_CYCLES, default 2500000: silent cycles inserted between two different notes.
REQ-003 Parameter SLOT_CYCLES, default 12500000: round-robin slot length in clk cycles; used only when REQ-029 applies.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sw  input  7  note request switches, asynchronous to clk; bit n requests note n.
REQ-007 enable  input  1  synchronous master enable; 0 forces silence.
REQ-008 speaker  output  1  square-wave drive to buzzer.
REQ-009 note_idx  output  3  index of the note currently selected.
REQ-010 note_valid  output  1  high while a note is sounding (PLAY state).

Function
REQ-011 sw SHALL pass through a 2-flop synchronizer; sw_s denotes its output, giving 2 cycles latency before any decision.
REQ-012 The FSM SHALL have exactly three states: IDLE, PLAY, GAP.
REQ-013 Selection candidate cand SHALL be the highest set bit index of sw_s (fixed priority, 6 highest).
REQ-014 IDLE: speaker=0, note_valid=0; if enable=1 and sw_s!=0, next state PLAY with cur<=cand, tone counter<=0, speaker<=0.
REQ-015 PLAY: tone counter increments each cycle; when it equals DIV[cur]-1 it SHALL clear to 0 and speaker SHALL toggle, giving period 2*DIV[cur] cycles.
REQ-016 PLAY with enable=0 or sw_s==0: next state IDLE; speaker=0 and tone counter=0 from the next cycle.
REQ-017 PLAY with cand!=cur (and REQ-016 not applicable): next state GAP; speaker=0, gap counter=0.
REQ-018 GAP: speaker=0, note_valid=0; gap counter increments; after GAP_CYCLES cycles in GAP, next state IDLE if enable=0 or sw_s==0, else PLAY with cur<=cand and tone counter=0.
REQ-019 enable=0 in GAP SHALL abort to IDLE next cycle.
REQ-020 note_valid SHALL be 1 exactly when state is PLAY; note_idx SHALL equal cur, holding its last value in IDLE and GAP.
REQ-021 Counters SHALL be 24 bits; DIVn and GAP_CYCLES values of 0 SHALL be treated as 1.
REQ-022 A switch change reaching sw_s on the same cycle that the tone counter wraps SHALL take precedence: state transition applies, speaker is forced to 0.
REQ-023 A press shorter than 1 cycle of sw_s visibility SHALL still start PLAY if sampled high in IDLE with enable=1, then return to IDLE on the next cycle.

Reset
REQ-024 On rst_n=0, asynchronously: state=IDLE, speaker=0, note_idx=0, note_valid=0, all counters and synchronizer flops=0.
REQ-025 Reset asserted mid-note SHALL silence speaker immediately, without waiting for clk.
REQ-026 After rst_n deasserts, first possible PLAY entry SHALL be 3 cycles after sw is held high (2 sync + 1 FSM).

Configuration
REQ-027 Macro BUZZ_ROUND_ROBIN_EN SHALL select the selection policy.
REQ-028 Without BUZZ_ROUND_ROBIN_EN: policy of REQ-013; slot counter and SLOT_CYCLES absent from logic.
REQ-029 With BUZZ_ROUND_ROBIN_EN: in PLAY, a slot counter counts cycles; cand=cur while sw_s[cur]=1 and slot count<SLOT_CYCLES-1; otherwise cand = next set bit of sw_s above cur, wrapping 6->0; if that is cur itself, slot counter clears and play continues without GAP.
REQ-030 With BUZZ_ROUND_ROBIN_EN, slot counter SHALL clear on every entry to PLAY; entry from IDLE uses the lowest set bit of sw_s.

Verification (DIV0..DIV6=4,5,6,7,8,9,10; GAP_CYCLES=3; SLOT_CYCLES=20)
REQ-031 sw=7'b0000001, enable=1 -> note_valid rises 3 cycles later, note_idx=0, speaker toggles every 4 cycles (period 8).
REQ-032 Holding bit 0, then add bit 5 -> note_valid low, speaker 0 for 3 GAP cycles, then note_idx=5, period 18; release bit 5 -> GAP then note_idx=0.
REQ-033 Note 6 playing, enable driven 0 -> IDLE next cycle, speaker 0; enable back to 1 -> PLAY note 6, counter restarted.
REQ-034 rst_n pulsed low for 3 ns mid-high-phase -> speaker, note_valid, note_idx go 0 without clk edge; FSM in IDLE.
REQ-035 BUZZ_ROUND_ROBIN_EN, sw=bits 1,3,4 held -> note_idx sequence 1,3,4,1 with 20-cycle PLAY slots separated by 3-cycle GAPs.
REQ-036 BUZZ_ROUND_ROBIN_EN, only bit 2 held for 60 cycles -> continuous note 2, no GAP, period 12.

Source files
------------

// File: rtl/buzz_note_scheduler.sv
// buzz_note_scheduler: picks one of seven requested notes (C4..B4) and drives a
// square wave to a buzzer, inserting a silent gap between two different notes.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   sw[6:0]    - note request switches (asynchronous to clk), bit n = note n
//   enable     - synchronous master enable, 0 forces silence
//   speaker    - square-wave drive, period 2*DIVn cycles while playing
//   note_idx   - index of the currently selected note (held outside PLAY)
//   note_valid - high while a note is sounding
//
// Build option: define BUZZ_ROUND_ROBIN_EN to rotate through all requested
// notes in SLOT_CYCLES slots; otherwise the highest requested note wins.
module buzz_note_scheduler #(
    parameter int unsigned DIV0        = 95557,
    parameter int unsigned DIV1        = 85131,
    parameter int unsigned DIV2        = 75843,
    parameter int unsigned DIV3        = 71586,
    parameter int unsigned DIV4        = 63776,
    parameter int unsigned DIV5        = 56818,
    parameter int unsigned DIV6        = 50619,
    parameter int unsigned GAP_CYCLES  = 2500000,
    parameter int unsigned SLOT_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] sw,
    input  logic       enable,
    output logic       speaker,
    output logic [2:0] note_idx,
    output logic       note_valid
);

    localparam int unsigned CNT_W = 24;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned NOTES = 7;

    // Terminal count (length-1) of a cycle length; a length of 0 acts as 1.
    function automatic logic [CNT_W-1:0] term_cnt(input int unsigned len);
        if (len == 0) return '0;
        return CNT_W'(len - 1);
    endfunction

    localparam logic [CNT_W-1:0] DIV0_TC = term_cnt(DIV0);
    localparam logic [CNT_W-1:0] DIV1_TC = term_cnt(DIV1);
    localparam logic [CNT_W-1:0] DIV2_TC = term_cnt(DIV2);
    localparam logic [CNT_W-1:0] DIV3_TC = term_cnt(DIV3);
    localparam logic [CNT_W-1:0] DIV4_TC = term_cnt(DIV4);
    localparam logic [CNT_W-1:0] DIV5_TC = term_cnt(DIV5);
    localparam logic [CNT_W-1:0] DIV6_TC = term_cnt(DIV6);
    localparam logic [CNT_W-1:0] GAP_TC  = term_cnt(GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state, w_state_nx;
    logic [6:0]         r_sw_meta, r_sw_s;
    logic [IDX_W-1:0]   r_cur, w_cur_nx;
    logic [CNT_W-1:0]   r_tone_cnt, w_tone_nx;
    logic [CNT_W-1:0]   r_gap_cnt, w_gap_nx;
    logic               r_speaker, w_spk_nx;
    logic               r_valid;
    logic [CNT_W-1:0]   w_div_tc;
    logic [IDX_W-1:0]   w_entry;
    logic [IDX_W-1:0]   w_cand;
    logic               w_any;

    // Two-flop synchronizer for the asynchronous switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta <= '0;
            r_sw_s    <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_s    <= r_sw_meta;
        end
    end

    assign w_any = |r_sw_s;

    // Half-period terminal count of the current note.
    always_comb begin
        w_div_tc = DIV0_TC;
        case (r_cur)
            3'd1:    w_div_tc = DIV1_TC;
            3'd2:    w_div_tc = DIV2_TC;
            3'd3:    w_div_tc = DIV3_TC;
            3'd4:    w_div_tc = DIV4_TC;
            3'd5:    w_div_tc = DIV5_TC;
            3'd6:    w_div_tc = DIV6_TC;
            default: w_div_tc = DIV0_TC;
        endcase
    end

`ifdef BUZZ_ROUND_ROBIN_EN
    localparam logic [CNT_W-1:0] SLOT_TC = term_cnt(SLOT_CYCLES);

    logic [CNT_W-1:0] r_slot_cnt, w_slot_nx;
    logic             w_keep;

    // Lowest requested note, used when starting from IDLE.
    function automatic logic [IDX_W-1:0] lowest(input logic [6:0] v);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int i = NOTES - 1; i >= 0; i--) begin
            if (v[i]) res = IDX_W'(i);
        end
        return res;
    endfunction

    // Next requested note strictly above cur, wrapping 6->0; cur itself is
    // examined last so a lone request returns cur.
    function automatic logic [IDX_W-1:0] next_above(input logic [6:0] v,
                                                    input logic [IDX_W-1:0] cur);
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] j;
        logic             found;
        res   = cur;
        j     = cur;
        found = 1'b0;
        for (int k = 0; k < NOTES; k++) begin
            j = (j == IDX_W'(NOTES - 1)) ? '0 : j + IDX_W'(1);
            if (!found && v[j]) begin
                res   = j;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign w_keep  = r_sw_s[r_cur] && (r_slot_cnt < SLOT_TC);
    assign w_entry = lowest(r_sw_s);
    assign w_cand  = w_keep ? r_cur : next_above(r_sw_s, r_cur);

    // Slot counter: cleared on PLAY entry and when the rotation lands on cur.
    always_comb begin
        w_slot_nx = r_slot_cnt;
        if ((w_state_nx == S_PLAY) && (r_state != S_PLAY)) begin
            w_slot_nx = '0;
        end else if ((r_state == S_PLAY) && (w_state_nx == S_PLAY)) begin
            w_slot_nx = w_keep ? r_slot_cnt + CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_slot_cnt <= '0;
        else        r_slot_cnt <= w_slot_nx;
    end
`else
    // Fixed priority: highest requested note.
    function automatic logic [IDX_W-1:0] highest(input logic [6:0] v);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int i = 0; i < NOTES; i++) begin
            if (v[i]) res = IDX_W'(i);
        end
        return res;
    endfunction

    assign w_entry = highest(r_sw_s);
    assign w_cand  = w_entry;
`endif

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cur      <= '0;
            r_tone_cnt <= '0;
            r_gap_cnt  <= '0;
            r_speaker  <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cur      <= w_cur_nx;
            r_tone_cnt <= w_tone_nx;
            r_gap_cnt  <= w_gap_nx;
            r_speaker  <= w_spk_nx;
            r_valid    <= (w_state_nx == S_PLAY);
        end
    end

    // Next-state logic; a state change always wins over a tone-counter wrap.
    always_comb begin
        w_state_nx = r_state;
        w_cur_nx   = r_cur;
        w_tone_nx  = r_tone_cnt;
        w_gap_nx   = r_gap_cnt;
        w_spk_nx   = r_speaker;
        case (r_state)
            S_IDLE: begin
                w_spk_nx  = 1'b0;
                w_tone_nx = '0;
                if (enable && w_any) begin
                    w_state_nx = S_PLAY;
                    w_cur_nx   = w_entry;
                end
            end
            S_PLAY: begin
                if (!enable || !w_any) begin
                    w_state_nx = S_IDLE;
                    w_spk_nx   = 1'b0;
                    w_tone_nx  = '0;
                end else if (w_cand != r_cur) begin
                    w_state_nx = S_GAP;
                    w_spk_nx   = 1'b0;
                    w_tone_nx  = '0;
                    w_gap_nx   = '0;
                end else if (r_tone_cnt == w_div_tc) begin
                    w_tone_nx = '0;
                    w_spk_nx  = ~r_speaker;
                end else begin
                    w_tone_nx = r_tone_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                w_spk_nx = 1'b0;
                if (!enable) begin
                    w_state_nx = S_IDLE;
                end else if (r_gap_cnt == GAP_TC) begin
                    if (!w_any) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_PLAY;
                        w_cur_nx   = w_cand;
                        w_tone_nx  = '0;
                    end
                end else begin
                    w_gap_nx = r_gap_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_spk_nx   = 1'b0;
            end
        endcase
    end

    assign speaker    = r_speaker;
    assign note_idx   = r_cur;
    assign note_valid = r_valid;

endmodule

// File: tb/tb_buzz_note_scheduler.sv
// Self-checking bench for buzz_note_scheduler: directed scenarios plus random
// switch/enable traffic, checked every cycle against a time-based model.
module tb_buzz_note_scheduler;

    localparam int unsigned GAP  = 3;
    localparam int unsigned SLOT = 20;
    localparam logic [1:0]  M_IDLE = 2'd0;
    localparam logic [1:0]  M_PLAY = 2'd1;
    localparam logic [1:0]  M_GAP  = 2'd2;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic [6:0] sw     = '0;
    logic       enable = 1'b0;
    logic       speaker;
    logic [2:0] note_idx;
    logic       note_valid;

    int  n_cmp  = 0;
    int  n_fail = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    buzz_note_scheduler #(
        .DIV0(4), .DIV1(5), .DIV2(6), .DIV3(7), .DIV4(8), .DIV5(9), .DIV6(10),
        .GAP_CYCLES(GAP), .SLOT_CYCLES(SLOT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .enable(enable),
        .speaker(speaker), .note_idx(note_idx), .note_valid(note_valid)
    );

    // Behavioural model: t counts cycles since the note started sounding, so
    // the speaker level is simply floor(t / DIV) mod 2.
    typedef struct packed {
        logic [6:0]  s1;
        logic [6:0]  s2;
        logic [1:0]  mode;
        logic [2:0]  note;
        int unsigned t;
        int unsigned g;
        int unsigned slot;
    } mdl_t;

    mdl_t m;

    function automatic int unsigned divv(input logic [2:0] n);
        return 4 + int'(n);
    endfunction

    function automatic logic [2:0] hi_bit(input logic [6:0] v);
        logic [2:0] r = 3'd0;
        for (int i = 0; i < 7; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic [2:0] lo_bit(input logic [6:0] v);
        logic [2:0] r = 3'd0;
        for (int i = 6; i >= 0; i--) if (v[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic [2:0] next_up(input logic [6:0] v, input logic [2:0] c);
        for (int k = 1; k <= 7; k++) begin
            if (v[(int'(c) + k) % 7]) return 3'((int'(c) + k) % 7);
        end
        return c;
    endfunction

    function automatic logic keep_cur(input mdl_t x);
        return x.s2[x.note] && (x.slot < SLOT - 1);
    endfunction

    function automatic logic [2:0] target(input mdl_t x);
`ifdef BUZZ_ROUND_ROBIN_EN
        return keep_cur(x) ? x.note : next_up(x.s2, x.note);
`else
        return hi_bit(x.s2);
`endif
    endfunction

    function automatic logic [2:0] entry(input mdl_t x);
`ifdef BUZZ_ROUND_ROBIN_EN
        return lo_bit(x.s2);
`else
        return hi_bit(x.s2);
`endif
    endfunction

    function automatic mdl_t step(input mdl_t x, input logic [6:0] s, input logic en);
        mdl_t n = x;
        case (x.mode)
            M_IDLE: if (en && x.s2 != 0) begin
                n.mode = M_PLAY; n.note = entry(x); n.t = 0; n.slot = 0;
            end
            M_PLAY: begin
                if (!en || x.s2 == 0) n.mode = M_IDLE;
                else if (target(x) != x.note) begin
                    n.mode = M_GAP; n.g = 0;
                end else begin
                    n.t = x.t + 1;
                    n.slot = keep_cur(x) ? x.slot + 1 : 0;
                end
            end
            default: begin
                if (!en) n.mode = M_IDLE;
                else if (x.g == GAP - 1) begin
                    if (x.s2 == 0) n.mode = M_IDLE;
                    else begin
                        n.mode = M_PLAY; n.note = target(x); n.t = 0; n.slot = 0;
                    end
                end else n.g = x.g + 1;
            end
        endcase
        n.s1 = s;
        n.s2 = x.s1;
        return n;
    endfunction

    function automatic logic exp_spk(input mdl_t x);
        return (x.mode == M_PLAY) && (((x.t / divv(x.note)) % 2) == 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= step(m, sw, enable);
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            n_cmp++;
            if (speaker !== exp_spk(m) || note_valid !== (m.mode == M_PLAY) ||
                note_idx !== m.note) begin
                n_fail++;
                $display("FAIL cycle_model @%0t: got spk=%b valid=%b idx=%0d, expected spk=%b valid=%b idx=%0d",
                         $time, speaker, note_valid, note_idx,
                         exp_spk(m), (m.mode == M_PLAY), m.note);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    logic [15:0] pat;
    int unsigned rr, hold;
    logic        found;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_speaker", speaker, 0);
        chk("rst_valid", note_valid, 0);
        chk("rst_idx", note_idx, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Single note 0: valid three cycles later, period 8.
        sw = 7'b0000001; enable = 1'b1;
        @(negedge clk); chk("lat_c1_valid", note_valid, 0);
        @(negedge clk); chk("lat_c2_valid", note_valid, 0);
        @(negedge clk); chk("lat_c3_valid", note_valid, 1);
        chk("lat_c3_idx", note_idx, 0);
        chk("model_play", m.mode, M_PLAY);
        pat = 16'hF0F0;
        for (int i = 0; i < 16; i++) begin
            chk("note0_wave", speaker, pat[i]);
            @(negedge clk);
        end

`ifndef BUZZ_ROUND_ROBIN_EN
        // Add note 5: three gap cycles then note 5; release returns to note 0.
        sw = 7'b0100001;
        repeat (3) @(negedge clk);
        chk("gap5_valid", note_valid, 0);
        chk("gap5_spk", speaker, 0);
        repeat (3) @(negedge clk);
        chk("play5_valid", note_valid, 1);
        chk("play5_idx", note_idx, 5);
        repeat (20) @(negedge clk);
        sw = 7'b0000001;
        repeat (3) @(negedge clk);
        chk("gap0_valid", note_valid, 0);
        repeat (3) @(negedge clk);
        chk("back0_idx", note_idx, 0);
        chk("back0_valid", note_valid, 1);
`endif

        // Note 6, enable dropped and restored.
        sw = 7'b1000000;
        repeat (8) @(negedge clk);
        chk("n6_valid", note_valid, 1);
        chk("n6_idx", note_idx, 6);
        enable = 1'b0;
        @(negedge clk);
        chk("en0_valid", note_valid, 0);
        chk("en0_spk", speaker, 0);
        enable = 1'b1;
        @(negedge clk);
        chk("en1_valid", note_valid, 1);
        chk("en1_idx", note_idx, 6);
        chk("en1_spk", speaker, 0);

`ifdef BUZZ_ROUND_ROBIN_EN
        // Rotation through notes 1,3,4,1 in 20-cycle slots with 3-cycle gaps.
        sw = 7'b0000000;
        repeat (5) @(negedge clk);
        sw = 7'b0011010;
        repeat (3) @(negedge clk);
        chk("rr_first_idx", note_idx, 1);
        repeat (19) @(negedge clk);
        chk("rr_slot_end_valid", note_valid, 1);
        @(negedge clk);
        chk("rr_gap_valid", note_valid, 0);
        repeat (3) @(negedge clk);
        chk("rr_second_idx", note_idx, 3);
        repeat (23) @(negedge clk);
        chk("rr_third_idx", note_idx, 4);
        repeat (23) @(negedge clk);
        chk("rr_wrap_idx", note_idx, 1);
        chk("rr_wrap_valid", note_valid, 1);
        // Lone note 2 plays continuously across slot boundaries.
        sw = 7'b0000100;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            chk("rr_lone_valid", note_valid, 1);
            @(negedge clk);
        end
`endif

        // Asynchronous reset pulse while the speaker is high.
        sw = 7'b0000100; enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (speaker) found = 1'b1;
        end
        chk("rst_wait_spk_high", found, 1);
        if (found) begin
            #1 rst_n = 1'b0;
            #1;
            chk("arst_spk", speaker, 0);
            chk("arst_valid", note_valid, 0);
            chk("arst_idx", note_idx, 0);
            chk("arst_model_idle", m.mode, M_IDLE);
            #2 rst_n = 1'b1;
        end

        // Random switch and enable traffic.
        for (int b = 0; b < 220; b++) begin
            @(negedge clk);
            rr = $urandom_range(0, 9);
            case (rr)
                0:          sw = '0;
                1, 2:       sw = 7'(1 << $urandom_range(0, 6));
                3, 4, 5, 6: sw = 7'($urandom) & 7'($urandom);
                default:    sw = sw ^ 7'(1 << $urandom_range(0, 6));
            endcase
            enable = ($urandom_range(0, 9) != 0);
            hold = ($urandom_range(0, 4) == 0) ? 1 : $urandom_range(2, 30);
            repeat (hold - 1) @(negedge clk);
        end
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
